cbc_stream_ctrl: RTL and testbench
==================================

Name:
cbc_stream_ctrl

Overview:
- Sequential CBC encrypt/decrypt engine for the exercise02 cipher family.
- Processes one message of M blocks, each 8*N bits, streamed one block per handshake.
- Holds the chaining register internally, so the message never has to be presented as one wide vector.
- Sits between a block source (valid/ready) and a block sink (valid/ready). A host controls it with start/mode/key.

Parameters:
- N, default 2: bytes per block; block width is 8*N.
- M, default 4: blocks per message; M >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start-of-message request; honoured only in IDLE.
- enc_dec  in  1  mode, 1=encrypt, 0=decrypt; sampled on an accepted start.
- key  in  8*N  IV/key; sampled on an accepted start.
- in_valid  in  1  source has a block on in_block.
- in_block  in  8*N  input block; block 0 first.
- in_ready  out  1  engine accepts in_block this cycle.
- out_valid  out  1  out_block holds a result.
- out_block  out  8*N  result block.
- out_ready  in  1  sink consumes out_block this cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of message.
- blk_idx  out  $clog2(M)+1  number of blocks accepted so far in the current message.

Behaviour:
- Reset (async, immediate on rst high, any state, mid-message included):
  - state=IDLE; prev=0; mode=0; blk_idx=0.
  - out_valid=0; out_block=0; done=0; busy=0; in_ready=0.
  - A partially processed message is abandoned; nothing resumes after reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start=1: prev<=key, mode<=enc_dec, blk_idx<=0, then go to RUN.
  - start while not IDLE is ignored.
  - key/enc_dec changes after start have no effect on the current message.
- RUN:
  - in_ready = !out_valid || out_ready (single-entry output register, full throughput).
  - Accept occurs when in_valid && in_ready. On accept:
    - out_block <= in_block ^ prev; out_valid <= 1.
    - If mode=1, prev <= in_block ^ prev (the ciphertext).
    - If mode=0, prev <= in_block (the incoming ciphertext).
    - blk_idx <= blk_idx+1.
  - If the accept makes blk_idx reach M, go to DRAIN.
  - Output handshake (out_valid && out_ready) with no new accept in the same cycle: out_valid <= 0.
  - Handshake and new accept in the same cycle: out_block is replaced and out_valid stays 1.
- Latency: one cycle from accept to out_valid. Sustained rate of 1 block/cycle when out_ready=1.
- Backpressure:
  - out_valid=1 and out_ready=0 forces in_ready=0.
  - out_block is held stable until consumed.
- Stall: in_valid=0 changes no state except draining of the output register.
- DRAIN:
  - in_ready=0.
  - On the handshake of the last result, out_valid <= 0 and go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - blk_idx holds M until the next start.
- M=1: RUN→DRAIN on the first accept.
- No width growth: all arithmetic is bitwise XOR on 8*N bits.
- Block ordering matches the combinational cipher: stream block i equals message slice [i*8N +: 8N].

Test Plan:
- Encrypt, N=2, M=4, key=0x1234, blocks 0x0001,0x0002,0x0003,0x0004, out_ready=1:
  - out_block sequence is 0x1235,0x1237,0x1234,0x1230.
  - Each result arrives 1 cycle after its accept.
  - done pulses one cycle after the last handshake; busy then drops.
- Decrypt, same key, blocks 0x1235,0x1237,0x1234,0x1230:
  - out_block sequence is 0x0001,0x0002,0x0003,0x0004.
- Backpressure: encrypt vector with out_ready=0 for 3 cycles after the first result:
  - in_ready=0 and out_block holds 0x1235 throughout.
  - Once released, the remaining outputs are unchanged (0x1237,0x1234,0x1230).
- Mode/key isolation: change key to 0xFFFF and enc_dec to 0 after start, and pulse start mid-RUN:
  - Outputs still equal the encrypt vector; busy stays 1; blk_idx is not reset.
- Async reset mid-message: assert rst after 2 blocks, between clock edges:
  - Outputs clear immediately: out_valid=0, busy=0, blk_idx=0.
  - A new start with key=0x1234 encrypting 0x0001 yields 0x1235.
- M=1 and source stalls: random in_valid gaps on the 4-block vector give identical outputs; with M=1, key=0x00FF, block 0x0F0F, result is 0x0FF0 followed by done.

Source files
------------

// File: rtl/cbc_stream_ctrl.sv
// rtl/cbc_stream_ctrl.sv - streaming CBC encrypt/decrypt engine, one block per handshake
// Chaining register lives here so the message is never presented as one wide vector.
module cbc_stream_ctrl #(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   enc_dec,
  input  logic [8*N-1:0]         key,
  input  logic                   in_valid,
  input  logic [8*N-1:0]         in_block,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [8*N-1:0]         out_block,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(M):0]     blk_idx
);

  localparam int W  = 8 * N;
  localparam int IW = $clog2(M) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    prev_q, prev_d;
  logic            mode_q, mode_d;
  logic [IW-1:0]   blk_idx_q, blk_idx_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_block_q, out_block_d;

  logic            accept;
  logic            out_hs;
  logic [W-1:0]    xor_blk;
  logic            last_blk;

  // Single-entry output register: a new block may enter whenever the slot is
  // empty or is being emptied in the same cycle.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign xor_blk  = in_block ^ prev_q;
  assign last_blk = (blk_idx_q == IW'(M - 1));

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    mode_d      = mode_q;
    blk_idx_d   = blk_idx_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d    = key;
          mode_d    = enc_dec;
          blk_idx_d = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (accept) begin
          out_block_d = xor_blk;
          out_valid_d = 1'b1;
          // Encrypt chains on the produced ciphertext, decrypt on the consumed one.
          prev_d      = mode_q ? xor_blk : in_block;
          blk_idx_d   = blk_idx_q + 1'b1;
          if (last_blk) begin
            state_d = S_DRAIN;
          end
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      mode_q      <= 1'b0;
      blk_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      blk_idx_q   <= blk_idx_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign blk_idx   = blk_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_cbc_stream_ctrl.sv
// tb/tb_cbc_stream_ctrl.sv - scoreboard bench for cbc_stream_ctrl
module tb_cbc_stream_ctrl;
  localparam int N = 2;
  localparam int M = 4;
  localparam int W = 8 * N;

  typedef logic [W-1:0] vec_t [4];

  logic          clk = 1'b0;
  logic          rst;
  logic          start, enc_dec, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [W-1:0]  key, in_block, out_block;
  logic [2:0]    blk_idx;

  logic          start1, enc1, in_valid1, in_ready1, out_valid1, out_ready1, busy1, done1;
  logic [W-1:0]  key1, in_block1, out_block1;
  logic [0:0]    blk_idx1;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            last_hs_cyc = 0;
  bit            lat_pend = 1'b0;
  logic [W-1:0]  exp_q [$];
  vec_t          enc_in, enc_out;

  always #5 clk = ~clk;

  cbc_stream_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .enc_dec(enc_dec), .key(key),
    .in_valid(in_valid), .in_block(in_block), .in_ready(in_ready),
    .out_valid(out_valid), .out_block(out_block), .out_ready(out_ready),
    .busy(busy), .done(done), .blk_idx(blk_idx)
  );

  cbc_stream_ctrl #(.N(N), .M(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .enc_dec(enc1), .key(key1),
    .in_valid(in_valid1), .in_block(in_block1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_block(out_block1), .out_ready(out_ready1),
    .busy(busy1), .done(done1), .blk_idx(blk_idx1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      lat_pend = 1'b0;
    end else begin
      if (lat_pend) check_val("latency", out_valid, 1);
      lat_pend = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_out", 1, 0);
        else check_val("out_block", out_block, exp_q.pop_front());
        last_hs_cyc = cyc;
      end
    end
  end

  task automatic start_msg(input bit enc, input logic [W-1:0] k);
    check_val("idle_in_ready", in_ready, 0);
    start = 1'b1; enc_dec = enc; key = k;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_blk_idx", blk_idx, 0);
  endtask

  task automatic send_msg(input bit enc, input logic [W-1:0] k, input vec_t blks,
                          input vec_t exps, input bit gaps, input int count, input bit disturb);
    bit accepted;
    start_msg(enc, k);
    if (disturb) begin
      key = 16'hFFFF; enc_dec = 1'b0;
    end
    for (int i = 0; i < count; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_block = blks[i];
      if (disturb && i == 2) start = 1'b1;
      accepted = 1'b0;
      for (int t = 0; t < 50 && !accepted; t++) begin
        @(negedge clk);
        if (in_ready) begin
          exp_q.push_back(exps[i]);
          accepted = 1'b1;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0; start = 1'b0;
      if (!accepted) check_val("accept_timeout", 0, 1);
      check_val("run_blk_idx", blk_idx, i + 1);
      check_val("run_busy", busy, 1);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("done_seen", seen, 1);
    check_val("done_lat", cyc - last_hs_cyc, 1);
    check_val("done_blk_idx", blk_idx, M);
    check_val("drained", exp_q.size(), 0);
    @(negedge clk);
    check_val("done_pulse", done, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_blk_idx", blk_idx, M);
    @(posedge clk); #1;
  endtask

  initial begin
    enc_in  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    enc_out = '{16'h1235, 16'h1237, 16'h1234, 16'h1230};
    rst = 1'b1; start = 1'b0; enc_dec = 1'b0; key = '0; in_valid = 1'b0; in_block = '0;
    out_ready = 1'b1;
    start1 = 1'b0; enc1 = 1'b0; key1 = '0; in_valid1 = 1'b0; in_block1 = '0; out_ready1 = 1'b1;
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_block", out_block, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_blk_idx", blk_idx, 0);
    check_val("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // encrypt and decrypt of the reference vector
    send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b0, 4, 1'b0);
    wait_done();
    send_msg(1'b0, 16'h1234, enc_out, enc_in, 1'b0, 4, 1'b0);
    wait_done();

    // backpressure after the first result
    out_ready = 1'b0;
    fork
      send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b0, 4, 1'b0);
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          check_val("bp_in_ready", in_ready, 0);
          check_val("bp_hold", out_block, 16'h1235);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done();

    // key/mode changes and start pulse mid-message are ignored
    send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b0, 4, 1'b1);
    wait_done();

    // random source stalls
    send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b1, 4, 1'b0);
    wait_done();

    // async reset mid-message
    send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b0, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_blk_idx", blk_idx, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_msg(1'b1, 16'h1234, enc_in, enc_out, 1'b0, 1, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    check_val("arst_restart_drained", exp_q.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // M=1 instance
    start1 = 1'b1; enc1 = 1'b1; key1 = 16'h00FF;
    @(posedge clk); #1;
    start1 = 1'b0;
    in_valid1 = 1'b1; in_block1 = 16'h0F0F;
    @(negedge clk);
    check_val("m1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check_val("m1_out_valid", out_valid1, 1);
    check_val("m1_out_block", out_block1, 16'h0FF0);
    check_val("m1_blk_idx", blk_idx1, 1);
    check_val("m1_drain_in_ready", in_ready1, 0);
    @(posedge clk); #1;
    check_val("m1_done", done1, 1);
    check_val("m1_out_cleared", out_valid1, 0);
    @(posedge clk); #1;
    check_val("m1_done_pulse", done1, 0);
    check_val("m1_idle_busy", busy1, 0);

    check_val("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
